// File: rtl/rf_scan_checker_if.sv
// Read-port bundle between the register-file scan checker and the RF / expected-value memories.
// The checker drives both indices; both memories return data one cycle after the index.
interface rf_scan_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic [ADDR_W-1:0] exp_rd_addr;
    logic [DATA_W-1:0] exp_rd_data;

    modport master (
        output rf_rd_addr,
        output exp_rd_addr,
        input  rf_rd_data,
        input  exp_rd_data
    );

    modport slave (
        input  rf_rd_addr,
        input  exp_rd_addr,
        output rf_rd_data,
        output exp_rd_data
    );
endinterface

// File: rtl/rf_scan_checker.sv
// Register-file self-checker: waits for core halt, scans every register against expected values.
// Optional RF_CHK_CAPTURE_EN adds first_err_act / first_err_exp capture of the first mismatch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for arm, all results zero
// ST_RUN  | core running, timeout down-counter active, watching for halt
// ST_SCAN | issuing indices and comparing one cycle behind
// ST_DONE | results held until arm or reset
module rf_scan_checker #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 38,
    parameter int ADDR_W     = 6,
    parameter int PC_W       = 32,
    parameter int MAX_CYCLES = 10000,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                arm,
    input  logic [31:0]         instr,
    input  logic [PC_W-1:0]     program_count,
    rf_scan_checker_if.master   scan,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_idx
`ifdef RF_CHK_CAPTURE_EN
    ,
    output logic [DATA_W-1:0]   first_err_act,
    output logic [DATA_W-1:0]   first_err_exp
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   SCAN_END  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   ERR_MAX   = '1;
    localparam logic [CNT_W-1:0]  RUN_LOAD  = CNT_W'(MAX_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic              start;
    logic              halt;
    logic              run_tc;
    logic              scan_last;
    logic              mismatch;
    logic [CNT_W-1:0]  run_cnt;
    logic [ADDR_W:0]   scan_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cmp_idx;

    assign halt      = (instr == '0) && (program_count != '0);
    assign run_tc    = (run_cnt == CNT_W'(1));
    assign scan_last = (scan_cnt == SCAN_END);
    assign mismatch  = (scan.rf_rd_data != scan.exp_rd_data);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt is tested before the terminal count so it wins a same-cycle tie.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_SCAN;
                end else if (run_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            run_cnt       <= '0;
            scan_cnt      <= '0;
            rd_addr       <= '0;
            cmp_idx       <= '0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
`ifdef RF_CHK_CAPTURE_EN
            first_err_act <= '0;
            first_err_exp <= '0;
`endif
        end else if (start) begin
            run_cnt       <= RUN_LOAD;
            scan_cnt      <= '0;
            rd_addr       <= '0;
            cmp_idx       <= '0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
`ifdef RF_CHK_CAPTURE_EN
            first_err_act <= '0;
            first_err_exp <= '0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (!halt) begin
                        run_cnt <= run_cnt - CNT_W'(1);
                        if (run_tc) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    scan_cnt <= scan_cnt + (ADDR_W + 1)'(1);
                    cmp_idx  <= rd_addr;
                    if (rd_addr != LAST_IDX) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                    // scan_cnt==0 is the issue-only cycle; no read data is back yet.
                    if ((scan_cnt != '0) && mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + (ADDR_W + 1)'(1);
                        end
                        if (err_count == '0) begin
                            first_err_idx <= cmp_idx;
`ifdef RF_CHK_CAPTURE_EN
                            first_err_act <= scan.rf_rd_data;
                            first_err_exp <= scan.exp_rd_data;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan.rf_rd_addr  = rd_addr;
    assign scan.exp_rd_addr = rd_addr;

    assign busy = (state == ST_RUN) || (state == ST_SCAN);
    assign done = (state == ST_DONE);
    assign pass = done && !timeout && (err_count == '0);
endmodule

// File: tb/tb_rf_scan_checker.sv
// Directed + randomized bench for rf_scan_checker against a run-level reference model.
// Checks capture ports too when built with RF_CHK_CAPTURE_EN.
module tb_rf_scan_checker;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 38;
    localparam int ADDR_W     = 6;
    localparam int PC_W       = 32;
    localparam int MAX_CYCLES = 100;
    localparam int CNT_W      = 16;

    logic              clk;
    logic              rstb;
    logic              arm;
    logic [31:0]       instr;
    logic [PC_W-1:0]   program_count;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_idx;
`ifdef RF_CHK_CAPTURE_EN
    logic [DATA_W-1:0] first_err_act;
    logic [DATA_W-1:0] first_err_exp;
`endif

    logic [DATA_W-1:0] rf_mem  [NUM_REGS];
    logic [DATA_W-1:0] exp_mem [NUM_REGS];

    int checks = 0;
    int errors = 0;

    rf_scan_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

    rf_scan_checker #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .PC_W(PC_W), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .arm(arm),
        .instr(instr),
        .program_count(program_count),
        .scan(sif.master),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .err_count(err_count),
        .first_err_idx(first_err_idx)
`ifdef RF_CHK_CAPTURE_EN
        ,
        .first_err_act(first_err_act),
        .first_err_exp(first_err_exp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data returns one cycle after the index.
    always @(posedge clk) begin
        sif.rf_rd_data  <= (int'(sif.rf_rd_addr) < NUM_REGS) ? rf_mem[sif.rf_rd_addr] : '0;
        sif.exp_rd_data <= (int'(sif.exp_rd_addr) < NUM_REGS) ? exp_mem[sif.exp_rd_addr] : '0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_equal();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_mem[i] = $urandom;
            rf_mem[i]  = exp_mem[i];
        end
    endtask

    task automatic corrupt(input int idx);
        rf_mem[idx] = exp_mem[idx] ^ ($urandom | 32'h1);
    endtask

    // One complete run from arm. halt_at: edge after arm at which halt is first shown (0 = never).
    // zero_pc_until: edges showing instr==0 with PC==0. arm_at / rst_at: edge with arm high / rstb low.
    task automatic do_run(input int halt_at, input int zero_pc_until, input int arm_at, input int rst_at);
        int errs;
        int first;
        int h;
        int done_edge;
        int n;
        bit stop;
        errs  = 0;
        first = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rf_mem[i] != exp_mem[i]) begin
                if (errs == 0) first = i;
                errs++;
            end
        end

        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        check("armed_state", {busy, done, pass, timeout, err_count, first_err_idx},
              {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0});

        h         = 0;
        done_edge = MAX_CYCLES;
        n         = 1;
        stop      = 1'b0;
        while (!stop && n <= MAX_CYCLES + NUM_REGS + 2) begin
            if (h == 0 && halt_at != 0 && n >= halt_at) begin
                instr         = 32'h0;
                program_count = PC_W'($urandom_range(1, 1000) * 4);
            end else if (h == 0 && n <= zero_pc_until) begin
                instr         = 32'h0;
                program_count = '0;
            end else begin
                instr         = $urandom | 32'h1;
                program_count = $urandom;
            end
            arm  = (n == arm_at);
            rstb = !(n == rst_at);
            @(posedge clk);
            #1;
            if (h == 0 && n <= MAX_CYCLES && instr == 32'h0 && program_count != '0) begin
                h         = n;
                done_edge = n + NUM_REGS + 1;
            end
            if (n == rst_at) begin
                rstb = 1'b1;
                arm  = 1'b0;
                check("reset_mid_scan", {busy, done, pass, timeout, err_count, first_err_idx, sif.rf_rd_addr, sif.exp_rd_addr},
                      64'd0);
`ifdef RF_CHK_CAPTURE_EN
                check("reset_capture", {first_err_act, first_err_exp}, 64'd0);
`endif
                return;
            end
            check("busy_done", {busy, done}, {(n < done_edge), (n >= done_edge)});
            if (n >= done_edge) stop = 1'b1;
            n++;
        end
        arm  = 1'b0;
        rstb = 1'b1;

        check("timeout", timeout, (h == 0));
        check("pass", pass, (h != 0 && errs == 0));
        check("err_count", err_count, (h != 0) ? errs : 0);
        check("first_err_idx", first_err_idx, (h != 0) ? first : 0);
        check("rd_addr_hold", {sif.rf_rd_addr, sif.exp_rd_addr},
              (h != 0) ? {6'(NUM_REGS - 1), 6'(NUM_REGS - 1)} : 12'd0);
`ifdef RF_CHK_CAPTURE_EN
        check("capture_act", first_err_act, (h != 0 && errs != 0) ? rf_mem[first] : 0);
        check("capture_exp", first_err_exp, (h != 0 && errs != 0) ? exp_mem[first] : 0);
`endif
        @(posedge clk);
        #1;
        check("done_holds", {done, busy}, 2'b10);
    endtask

    initial begin
        rstb          = 1'b0;
        arm           = 1'b0;
        instr         = '0;
        program_count = '0;
        fill_equal();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, pass, timeout, err_count, first_err_idx, sif.rf_rd_addr, sif.exp_rd_addr},
              64'd0);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_arm", {busy, done}, 2'b00);

        // clean scan, halt at 50
        fill_equal();
        do_run(50, 0, 0, 0);

        // mismatches at 3 and 33
        corrupt(3);
        corrupt(33);
        do_run(30, 0, 0, 0);

        // no halt: timeout at MAX_CYCLES
        do_run(0, 0, 0, 0);

        // instr==0 with PC==0 must not count as halt
        fill_equal();
        do_run(21, 20, 0, 0);

        // reset at scan index 10 with errors already pending, then a clean run
        corrupt(2);
        corrupt(5);
        do_run(40, 0, 0, 51);
        fill_equal();
        do_run(15, 0, 0, 0);

        // arm during scan ignored; then a failing run followed by re-arm from DONE
        do_run(50, 0, 60, 0);
        corrupt(0);
        corrupt(17);
        corrupt(37);
        do_run(7, 0, 0, 0);
        fill_equal();
        do_run(12, 0, 0, 0);

        // halt coinciding with the limit, and halt on the first run cycle
        corrupt(37);
        do_run(MAX_CYCLES, 0, 0, 0);
        do_run(1, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            int nmis;
            int hat;
            fill_equal();
            nmis = $urandom_range(0, 5);
            for (int k = 0; k < nmis; k++) corrupt($urandom_range(0, NUM_REGS - 1));
            hat = $urandom_range(1, MAX_CYCLES - 1);
            do_run(hat, $urandom_range(0, 10), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
